vec_mem_stage: RTL and testbench
================================

VEC_MEM_STAGE -- requirements
Module: vec_mem_stage

Interface
REQ-001 Parameters SHALL be: LANES, default 20, vector element count; ELEM_W, default 8, element width; ADDR_W, default 16, element-address width; BEAT, default 4, elements per memory beat; LANES SHALL be a multiple of BEAT; NBEATS = LANES/BEAT.
REQ-002 Ports SHALL be (name direction width meaning):
 clk  in  1  single clock, rising edge
 rst  in  1  reset, asynchronous, active-low
 start  in  1  operation request, sampled only in IDLE
 op_type  in  1  0 scalar, 1 vector
 mem_op  in  1  1 memory access, 0 ALU pass-through
 write_enable  in  1  1 store, 0 load (mem_op=1 only)
 address  in  ADDR_W  base element address
 alu_result_v  in  LANES*ELEM_W  vector ALU result
 alu_result_s  in  ELEM_W  scalar ALU result
 rd2_vec  in  LANES*ELEM_W  vector store data
 rd2_sca  in  ELEM_W  scalar store data
 mem_req  out  1  beat request
 mem_we  out  1  beat is write
 mem_addr  out  ADDR_W  beat element address
 mem_be  out  BEAT  per-element enable
 mem_wdata  out  BEAT*ELEM_W  write beat, element 0 in LSBs
 mem_gnt  in  1  memory accepts beat this cycle
 mem_rvalid  in  1  read beat returned
 mem_rdata  in  BEAT*ELEM_W  read beat
 vector_output  out  LANES*ELEM_W  vector result
 scalar_output  out  ELEM_W  scalar result
 busy  out  1  operation in progress
 mem_finished  out  1  one-cycle completion pulse

Function
REQ-003 FSM states SHALL be IDLE, REQ, WAIT_R, DONE; busy=1 in every state except IDLE.
REQ-004 IDLE with start=1 SHALL capture all operand inputs into internal registers, clear the beat counter, then go to DONE if mem_op=0, else REQ; start outside IDLE SHALL be ignored.
REQ-005 Pass-through (mem_op=0) SHALL load vector_output or scalar_output (per op_type) from the captured ALU result on entry to DONE.
REQ-006 In REQ, mem_req=1; mem_we, mem_addr, mem_be, mem_wdata SHALL stay stable until mem_gnt=1.
REQ-007 Beat k address SHALL be captured address + k*BEAT, modulo 2^ADDR_W (wraps).
REQ-008 Vector access SHALL issue NBEATS beats, k=0..NBEATS-1, mem_be all ones, store beat k carrying rd2_vec elements k*BEAT..k*BEAT+BEAT-1.
REQ-009 Scalar access SHALL issue one beat with mem_be=...0001, element 0 = rd2_sca on store, other elements zero.
REQ-010 Store: on mem_gnt, increment k; after last beat granted, go to DONE; back-to-back beats SHALL occur with no idle cycle when mem_gnt stays high.
REQ-011 Load: on mem_gnt go to WAIT_R (one outstanding beat max); on mem_rvalid write beat k into vector_output elements k*BEAT.. (vector) or mem_rdata element 0 into scalar_output (scalar), then REQ for the next beat or DONE after the last; mem_rvalid outside WAIT_R SHALL be ignored.
REQ-012 mem_rvalid in the same cycle as mem_gnt SHALL NOT be accepted; earliest read return is the cycle after grant.
REQ-013 DONE SHALL assert mem_finished for exactly one cycle and return to IDLE; start in DONE is ignored.
REQ-014 Load writes only the lanes of returned beats; outputs not targeted by an operation, and all outputs on store, SHALL hold their value.
REQ-015 Latency with mem_gnt tied high and rvalid one cycle after grant: pass-through 2 cycles start-to-finished; vector store NBEATS+2; vector load 2*NBEATS+2.

Reset
REQ-016 rst=0 SHALL asynchronously force IDLE, k=0, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, vector_output=0, scalar_output=0, busy=0, mem_finished=0.
REQ-017 Reset mid-operation SHALL abandon the access; no mem_finished; late mem_rvalid after release SHALL be ignored.

Verification
REQ-018 Pass-through: start, mem_op=0, op_type=1, alu_result_v lanes 50..69 -> finished at cycle 2, vector_output lanes 50..69, no mem_req.
REQ-019 Vector store, address 0x0010, rd2_vec 100..119, gnt high -> 5 beats addr 0x10,0x14,0x18,0x1C,0x20, wdata {100..103}...{116..119}, finished at cycle 7.
REQ-020 Vector load with mem_gnt low 3 cycles on beat 2 -> mem_req and mem_addr held stable, lanes filled correctly, finished delayed 3 cycles.
REQ-021 Wrap: vector load, address 0xFFFC -> beat addresses 0xFFFC,0x0000,0x0004,0x0008,0x000C.
REQ-022 Scalar store rd2_sca=0xAB at 0x1234 -> one beat, mem_be=0001, wdata=0x000000AB; scalar load returning 0x000000CD -> scalar_output=0xCD, vector_output unchanged.
REQ-023 rst low during load beat 3, start pulsed while busy earlier -> all outputs zero immediately, no mem_finished, second start never executed.

Source files
------------

// File: rtl/vec_mem_stage.sv
// Memory stage for a vector/scalar pipeline: ALU pass-through or beat-wise load/store
// of LANES elements over a BEAT-element memory port with request/grant/read-valid handshake.
module vec_mem_stage #(
    parameter int LANES  = 20,
    parameter int ELEM_W = 8,
    parameter int ADDR_W = 16,
    parameter int BEAT   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      op_type,
    input  logic                      mem_op,
    input  logic                      write_enable,
    input  logic [ADDR_W-1:0]         address,
    input  logic [LANES*ELEM_W-1:0]   alu_result_v,
    input  logic [ELEM_W-1:0]         alu_result_s,
    input  logic [LANES*ELEM_W-1:0]   rd2_vec,
    input  logic [ELEM_W-1:0]         rd2_sca,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [BEAT-1:0]           mem_be,
    output logic [BEAT*ELEM_W-1:0]    mem_wdata,
    input  logic                      mem_gnt,
    input  logic                      mem_rvalid,
    input  logic [BEAT*ELEM_W-1:0]    mem_rdata,
    output logic [LANES*ELEM_W-1:0]   vector_output,
    output logic [ELEM_W-1:0]         scalar_output,
    output logic                      busy,
    output logic                      mem_finished
);

    localparam int NBEATS = LANES / BEAT;
    localparam int KW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int VW     = LANES * ELEM_W;
    localparam int BW     = BEAT * ELEM_W;
    localparam logic [KW-1:0] K_LAST = KW'(NBEATS - 1);
    localparam logic [KW-1:0] K_ONE  = KW'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [KW-1:0]       k_q, k_d;
    logic                vec_q, vec_d;
    logic                memop_q, memop_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [VW-1:0]       alu_v_q, alu_v_d;
    logic [ELEM_W-1:0]   alu_s_q, alu_s_d;
    logic [VW-1:0]       wd_vec_q, wd_vec_d;
    logic [ELEM_W-1:0]   wd_sca_q, wd_sca_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [BEAT-1:0]     mem_be_q, mem_be_d;
    logic [BW-1:0]       mem_wdata_q, mem_wdata_d;
    logic [VW-1:0]       vout_q, vout_d;
    logic [ELEM_W-1:0]   sout_q, sout_d;
    logic                busy_q, busy_d;
    logic                fin_q, fin_d;
    logic                last_s;

    // Beat k starts k*BEAT elements past the base; the sum wraps in ADDR_W bits.
    function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [KW-1:0]     k);
        beat_addr = base + (ADDR_W'(k) * ADDR_W'(BEAT));
    endfunction

    function automatic logic [BW-1:0] vec_beat(input logic [VW-1:0] v,
                                               input logic [KW-1:0] k);
        vec_beat = v[int'(k)*BW +: BW];
    endfunction

    assign last_s = vec_q ? (k_q == K_LAST) : 1'b1;

    // Next-state, operand capture, result update and memory-port drive.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        vec_d       = vec_q;
        memop_d     = memop_q;
        we_d        = we_q;
        addr_d      = addr_q;
        alu_v_d     = alu_v_q;
        alu_s_d     = alu_s_q;
        wd_vec_d    = wd_vec_q;
        wd_sca_d    = wd_sca_q;
        mem_req_d   = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        vout_d      = vout_q;
        sout_d      = sout_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    vec_d    = op_type;
                    memop_d  = mem_op;
                    we_d     = write_enable;
                    addr_d   = address;
                    alu_v_d  = alu_result_v;
                    alu_s_d  = alu_result_s;
                    wd_vec_d = rd2_vec;
                    wd_sca_d = rd2_sca;
                    k_d      = '0;
                    state_d  = mem_op ? REQ : DONE;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    if (!we_q) begin
                        state_d = WAIT_R;
                    end else if (last_s) begin
                        state_d = DONE;
                    end else begin
                        k_d     = k_q + K_ONE;
                        state_d = REQ;
                    end
                end else begin
                    state_d = REQ;
                end
            end
            WAIT_R: begin
                if (mem_rvalid) begin
                    if (vec_q) begin
                        vout_d[int'(k_q)*BW +: BW] = mem_rdata;
                    end else begin
                        sout_d = mem_rdata[ELEM_W-1:0];
                    end
                    if (last_s) begin
                        state_d = DONE;
                    end else begin
                        k_d     = k_q + K_ONE;
                        state_d = REQ;
                    end
                end else begin
                    state_d = WAIT_R;
                end
            end
            DONE: begin
                if (!memop_q) begin
                    if (vec_q) begin
                        vout_d = alu_v_q;
                    end else begin
                        sout_d = alu_s_q;
                    end
                end else begin
                    vout_d = vout_q;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Beat fields are recomputed from stable captured state, so they hold while ungranted.
        if (state_d == REQ) begin
            mem_req_d  = 1'b1;
            mem_we_d   = we_d;
            mem_addr_d = beat_addr(addr_d, k_d);
            mem_be_d   = vec_d ? {BEAT{1'b1}} : BEAT'(1'b1);
            if (!we_d) begin
                mem_wdata_d = '0;
            end else if (vec_d) begin
                mem_wdata_d = vec_beat(wd_vec_d, k_d);
            end else begin
                mem_wdata_d = BW'(wd_sca_d);
            end
        end else begin
            mem_req_d = 1'b0;
        end

        busy_d = (state_d != IDLE);
        fin_d  = (state_q == DONE);
    end

    // State and registered outputs; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            vec_q       <= 1'b0;
            memop_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            alu_v_q     <= '0;
            alu_s_q     <= '0;
            wd_vec_q    <= '0;
            wd_sca_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            vout_q      <= '0;
            sout_q      <= '0;
            busy_q      <= 1'b0;
            fin_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            vec_q       <= vec_d;
            memop_q     <= memop_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            alu_v_q     <= alu_v_d;
            alu_s_q     <= alu_s_d;
            wd_vec_q    <= wd_vec_d;
            wd_sca_q    <= wd_sca_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            vout_q      <= vout_d;
            sout_q      <= sout_d;
            busy_q      <= busy_d;
            fin_q       <= fin_d;
        end
    end

    assign mem_req       = mem_req_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_be        = mem_be_q;
    assign mem_wdata     = mem_wdata_q;
    assign vector_output = vout_q;
    assign scalar_output = sout_q;
    assign busy          = busy_q;
    assign mem_finished  = fin_q;

endmodule

// File: tb/tb_vec_mem_stage.sv
// Directed bench for vec_mem_stage: table of operations against a small memory model,
// plus hand sequences for idle read-valid and mid-load reset.
module tb_vec_mem_stage;

    localparam int LANES  = 20;
    localparam int ELEM_W = 8;
    localparam int ADDR_W = 16;
    localparam int BEAT   = 4;
    localparam int NB     = LANES / BEAT;
    localparam int VW     = LANES * ELEM_W;
    localparam int BW     = BEAT * ELEM_W;

    logic              clk, rst, start, op_type, mem_op, write_enable;
    logic [ADDR_W-1:0] address;
    logic [VW-1:0]     alu_result_v, rd2_vec;
    logic [ELEM_W-1:0] alu_result_s, rd2_sca;
    logic              mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [ADDR_W-1:0] mem_addr;
    logic [BEAT-1:0]   mem_be;
    logic [BW-1:0]     mem_wdata, mem_rdata;
    logic [VW-1:0]     vector_output;
    logic [ELEM_W-1:0] scalar_output;
    logic              busy, mem_finished;

    vec_mem_stage #(.LANES(LANES), .ELEM_W(ELEM_W), .ADDR_W(ADDR_W), .BEAT(BEAT)) dut (
        .clk(clk), .rst(rst), .start(start), .op_type(op_type), .mem_op(mem_op),
        .write_enable(write_enable), .address(address), .alu_result_v(alu_result_v),
        .alu_result_s(alu_result_s), .rd2_vec(rd2_vec), .rd2_sca(rd2_sca),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .vector_output(vector_output), .scalar_output(scalar_output),
        .busy(busy), .mem_finished(mem_finished)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          op_type;
        bit          mem_op;
        bit          we;
        bit          early_rv;
        logic [15:0] addr;
        logic [7:0]  dbase;
        logic [7:0]  sval;
        int          stall;
        int          exp_lat;
        int          exp_beats;
    } op_t;

    op_t tbl [0:7];

    int total, passed;
    bit          pend_rd;
    logic [15:0] pend_addr;
    logic [3:0]  pend_be;
    logic [15:0] b_addr [$];
    logic        b_we   [$];
    logic [3:0]  b_be   [$];
    logic [31:0] b_wd   [$];
    logic [VW-1:0]     exp_v;
    logic [ELEM_W-1:0] exp_s;

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ 8'hF9;
    endfunction

    function automatic logic [31:0] mem_beat(input logic [15:0] a, input logic [3:0] be);
        logic [31:0] r;
        r = 32'h0;
        for (int j = 0; j < 4; j++) begin
            if (be[j]) r[j*8 +: 8] = mem_byte(a + 16'(j));
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [159:0] got, input logic [159:0] exp);
        total++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end else begin
            passed++;
        end
    endtask

    // One clock of memory-side behaviour; called #1 after a rising edge.
    task automatic step(input bit allow, input bit early);
        mem_rvalid = pend_rd;
        mem_rdata  = pend_rd ? mem_beat(pend_addr, pend_be) : 32'h0;
        pend_rd    = 1'b0;
        mem_gnt    = mem_req & allow;
        if (mem_gnt) begin
            b_addr.push_back(mem_addr);
            b_we.push_back(mem_we);
            b_be.push_back(mem_be);
            b_wd.push_back(mem_wdata);
            if (!mem_we) begin
                pend_rd   = 1'b1;
                pend_addr = mem_addr;
                pend_be   = mem_be;
                if (early) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = 32'hEEEE_EEEE;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input op_t o, input int idx);
        logic [VW-1:0] av, rv;
        logic [15:0]   ea;
        logic [31:0]   ewd;
        int lat, stall_left, nchk;
        for (int i = 0; i < LANES; i++) begin
            av[i*8 +: 8] = o.dbase + 8'(i);
            rv[i*8 +: 8] = o.mem_op ? (o.dbase + 8'(i)) : (o.dbase + 8'(i) + 8'h80);
        end
        b_addr.delete(); b_we.delete(); b_be.delete(); b_wd.delete();
        op_type      = o.op_type;
        mem_op       = o.mem_op;
        write_enable = o.we;
        address      = o.addr;
        alu_result_v = av;
        rd2_vec      = rv;
        alu_result_s = o.mem_op ? 8'h11 : o.sval;
        rd2_sca      = o.mem_op ? o.sval : 8'h22;
        start        = 1'b1;
        step(1'b1, 1'b0);
        start = 1'b0;
        lat   = 1;
        chk($sformatf("op%0d busy", idx), 160'(busy), 160'(1'b1));
        stall_left = o.stall;
        while (!mem_finished && lat < 60) begin
            if (stall_left > 0 && mem_req && b_addr.size() == 2) begin
                stall_left--;
                chk($sformatf("op%0d stall hold", idx), 160'({mem_req, mem_addr}),
                    160'({1'b1, o.addr + 16'd8}));
                step(1'b0, o.early_rv);
            end else begin
                step(1'b1, o.early_rv);
            end
            lat++;
        end
        chk($sformatf("op%0d latency", idx), 160'(lat), 160'(o.exp_lat));

        if (!o.mem_op) begin
            if (o.op_type) exp_v = av;
            else           exp_s = o.sval;
        end else if (!o.we) begin
            if (o.op_type) begin
                for (int i = 0; i < LANES; i++) exp_v[i*8 +: 8] = mem_byte(o.addr + 16'(i));
            end else begin
                exp_s = mem_byte(o.addr);
            end
        end
        chk($sformatf("op%0d vector_output", idx), vector_output, exp_v);
        chk($sformatf("op%0d scalar_output", idx), 160'(scalar_output), 160'(exp_s));

        chk($sformatf("op%0d beat count", idx), 160'(b_addr.size()), 160'(o.exp_beats));
        nchk = (b_addr.size() < o.exp_beats) ? b_addr.size() : o.exp_beats;
        for (int k = 0; k < nchk; k++) begin
            ea  = o.addr + 16'(k * 4);
            ewd = o.op_type ? rv[k*32 +: 32] : {24'h0, o.sval};
            chk($sformatf("op%0d beat%0d addr/we/be", idx, k),
                160'({b_addr[k], b_we[k], b_be[k]}),
                160'({ea, o.we, (o.op_type ? 4'hF : 4'h1)}));
            if (o.we) chk($sformatf("op%0d beat%0d wdata", idx, k), 160'(b_wd[k]), 160'(ewd));
        end
        step(1'b1, 1'b0);
        chk($sformatf("op%0d finished one cycle", idx), 160'({mem_finished, busy}), 160'(2'b00));
    endtask

    initial begin
        bit saw_fin, saw_req, saw_busy;
        int cnt;
        total = 0; passed = 0; pend_rd = 1'b0;
        rst = 1'b0; start = 1'b0; op_type = 1'b0; mem_op = 1'b0; write_enable = 1'b0;
        address = 16'h0; alu_result_v = '0; alu_result_s = 8'h0; rd2_vec = '0; rd2_sca = 8'h0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        exp_v = '0; exp_s = 8'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset vector_output", vector_output, 160'h0);
        chk("reset scalar/control", 160'({scalar_output, mem_req, mem_we, busy, mem_finished,
            mem_be, mem_addr, mem_wdata}), 160'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        //          type  mop   we    early addr      dbase  sval   stall lat beats
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'd50,  8'h00, 0,    2,  0};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'd7,   8'h77, 0,    2,  0};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0010, 8'd100, 8'h00, 0,    7,  5};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0040, 8'd0,   8'h00, 3,    15, 5};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFC, 8'd0,   8'h00, 0,    12, 5};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h1234, 8'd0,   8'hAB, 0,    3,  1};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h1234, 8'd0,   8'h00, 0,    4,  1};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0200, 8'd0,   8'h00, 0,    12, 5};
        for (int i = 0; i < 8; i++) run_op(tbl[i], i);

        // Read-valid while idle must not touch the results.
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        @(posedge clk);
        #1;
        mem_rvalid = 1'b0;
        chk("idle rvalid vector", vector_output, exp_v);
        chk("idle rvalid scalar", 160'(scalar_output), 160'(exp_s));

        // Reset during beat 3 of a load, with an ignored start issued while busy.
        b_addr.delete(); b_we.delete(); b_be.delete(); b_wd.delete();
        op_type = 1'b1; mem_op = 1'b1; write_enable = 1'b0; address = 16'h0100;
        start = 1'b1;
        step(1'b1, 1'b0);
        start = 1'b0;
        step(1'b1, 1'b0);
        mem_op = 1'b0; address = 16'h0F00;
        for (int i = 0; i < LANES; i++) alu_result_v[i*8 +: 8] = 8'hC3;
        start = 1'b1;
        step(1'b1, 1'b0);
        start = 1'b0;
        cnt = 0;
        while (!(b_addr.size() == 3 && mem_req) && cnt < 40) begin
            step(1'b1, 1'b0);
            cnt++;
        end
        chk("reset test reached beat3", 160'({mem_req, 8'(b_addr.size())}), 160'({1'b1, 8'd3}));
        rst = 1'b0;
        #1;
        chk("async reset vector_output", vector_output, 160'h0);
        chk("async reset scalar/control", 160'({scalar_output, mem_req, mem_we, busy,
            mem_finished, mem_be, mem_addr, mem_wdata}), 160'h0);
        @(posedge clk);
        #1;
        rst = 1'b1; pend_rd = 1'b0;
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hA5A5_A5A5;
        saw_fin = 1'b0; saw_req = 1'b0; saw_busy = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            mem_rvalid = 1'b0;
            saw_fin  = saw_fin | mem_finished;
            saw_req  = saw_req | mem_req;
            saw_busy = saw_busy | busy;
        end
        mem_gnt = 1'b0;
        chk("after reset no finished/req/busy", 160'({saw_fin, saw_req, saw_busy}), 160'(3'b000));
        chk("after reset late rvalid ignored", vector_output, 160'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
